ysyx_23060240_mem_arbiter: RTL and testbench
============================================

YSYX_23060240_MEM_ARBITER -- requirements
Module: ysyx_23060240_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of all address ports.
REQ-002 Parameter DATA_W, 32, width of all data ports.
REQ-003 Parameter MASK_W, 8, width of write-mask ports.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, all state on posedge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ifu_req_valid  in  1  IFU read request valid.
REQ-008 ifu_req_ready  out  1  IFU request accepted this cycle when valid&ready.
REQ-009 ifu_addr  in  ADDR_W  IFU read address.
REQ-010 ifu_resp_valid  out  1  IFU read data valid.
REQ-011 ifu_resp_ready  in  1  IFU consumes response.
REQ-012 ifu_rdata  out  DATA_W  IFU read data.
REQ-013 lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake.
REQ-014 lsu_wen  in  1  1 = write, 0 = read.
REQ-015 lsu_addr / lsu_wdata / lsu_wmask  in  ADDR_W / DATA_W / MASK_W  LSU request payload.
REQ-016 lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake.
REQ-017 lsu_rdata  out  DATA_W  LSU read data, 0 for writes.
REQ-018 mem_r_en / mem_w_en  out  1  SRAM read / write enable.
REQ-019 mem_raddr / mem_waddr  out  ADDR_W  SRAM read / write address.
REQ-020 mem_wdata / mem_wmask  out  DATA_W / MASK_W  SRAM write data / mask.
REQ-021 mem_rdata  in  DATA_W  SRAM read data, registered, valid the cycle after mem_r_en.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction in flight at most.
REQ-023 Only in IDLE SHALL req_ready be asserted, combinationally, to the granted requester only; the other sees 0.
REQ-024 Grant: only one valid -> that one; both valid -> round-robin pointer; pointer resets to favour IFU and flips to the other requester after each accepted transaction.
REQ-025 On accept, address/wdata/wmask/wen and grant SHALL be latched; IDLE -> ISSUE.
REQ-026 ISSUE: exactly one cycle of mem_r_en (read) or mem_w_en (write), addresses/data from latched registers; read -> WAIT, write -> RESP.
REQ-027 WAIT: mem_rdata captured into response register at cycle end; -> RESP.
REQ-028 RESP: granted resp_valid held high with stable rdata until resp_ready; on handshake -> IDLE.
REQ-029 Latency from accept edge: read response valid 3 cycles later, write response 2 cycles later; back-to-back accepts no closer than 1 cycle after response handshake.
REQ-030 mem_r_en and mem_w_en SHALL never be high together and SHALL be 0 outside ISSUE; each accepted write produces exactly one mem_w_en cycle.
REQ-031 lsu_wmask SHALL be forwarded unchanged (mask 0 still issues a write); IFU requests are always reads.
REQ-032 A new request arriving during resp handshake SHALL wait until IDLE; requesters holding valid keep payload stable.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, pointer to IFU, all outputs and latched registers to 0.
REQ-034 Reset mid-transaction SHALL drop it with no response and no further mem enable.

Structure
REQ-035 Package ysyx_23060240_mem_pkg SHALL hold the state enum, grant encoding (GNT_IFU, GNT_LSU) and default widths.
REQ-036 Grant logic SHALL be one sub-module ysyx_23060240_rr_arb2 (2-way round-robin, pointer update input).

Verification
REQ-037 IFU read 0x80000000, mem returns 0xDEADBEEF -> one mem_r_en cycle, ifu_resp_valid 3 cycles after accept, ifu_rdata 0xDEADBEEF.
REQ-038 LSU write addr 0x80000010 data 0x12345678 mask 0x0F -> single mem_w_en cycle with those values, lsu_resp_valid 2 cycles after accept, lsu_rdata 0.
REQ-039 Both valid continuously from reset -> grants IFU, LSU, IFU, LSU alternately.
REQ-040 resp_ready held 0 for 5 cycles -> resp_valid and rdata stable, no new mem enable, no ready to either requester.
REQ-041 rst_n asserted during WAIT -> outputs 0 immediately, no response after release, next request served normally with IFU priority.

Source files
------------

// File: rtl/ysyx_23060240_mem_pkg.sv
// Shared types for the IFU/LSU single-port memory arbiter.
// Holds the controller states, the grant encoding and the default port widths.
package ysyx_23060240_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MASK_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  function automatic gnt_e gnt_other(input gnt_e g);
    return (g == GNT_IFU) ? GNT_LSU : GNT_IFU;
  endfunction

endpackage

// File: rtl/ysyx_23060240_rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on contention the
// pointer decides, and each accepted grant hands priority to the other side.
module ysyx_23060240_rr_arb2
  import ysyx_23060240_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output gnt_e       gnt,
  output logic       gnt_vld
);

  gnt_e ptr;

  always_comb begin
    gnt = ptr;
    if (req[0] && !req[1]) gnt = GNT_IFU;
    else if (!req[0] && req[1]) gnt = GNT_LSU;
  end

  assign gnt_vld = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= GNT_IFU;
    else if (upd) ptr <= gnt_other(gnt);
  end

endmodule

// File: rtl/ysyx_23060240_mem_arbiter.sv
// Arbitrates IFU reads and LSU reads/writes onto one registered-read SRAM port,
// one transaction in flight: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
module ysyx_23060240_mem_arbiter
  import ysyx_23060240_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MASK_W = DEF_MASK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state, state_nxt;
  gnt_e              gnt, gnt_q;
  logic              gnt_vld, accept, issue, resp, resp_hs;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [MASK_W-1:0] wmask_q;

  ysyx_23060240_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({lsu_req_valid, ifu_req_valid}),
    .upd     (accept),
    .gnt     (gnt),
    .gnt_vld (gnt_vld)
  );

  assign accept        = (state == S_IDLE) && gnt_vld;
  assign ifu_req_ready = accept && (gnt == GNT_IFU);
  assign lsu_req_ready = accept && (gnt == GNT_LSU);

  assign issue   = (state == S_ISSUE);
  assign resp    = (state == S_RESP);
  assign resp_hs = resp && ((gnt_q == GNT_IFU) ? ifu_resp_ready : lsu_resp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = wen_q ? S_RESP : S_WAIT;
      S_WAIT:  state_nxt = S_RESP;
      S_RESP:  if (resp_hs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response register is cleared on accept so write responses carry zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= GNT_IFU;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        gnt_q   <= gnt;
        rdata_q <= '0;
        if (gnt == GNT_LSU) begin
          wen_q   <= lsu_wen;
          addr_q  <= lsu_addr;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end else begin
          wen_q   <= 1'b0;
          addr_q  <= ifu_addr;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
      if (state == S_WAIT) rdata_q <= mem_rdata;
    end
  end

  assign mem_r_en  = issue && !wen_q;
  assign mem_w_en  = issue && wen_q;
  assign mem_raddr = mem_r_en ? addr_q  : '0;
  assign mem_waddr = mem_w_en ? addr_q  : '0;
  assign mem_wdata = mem_w_en ? wdata_q : '0;
  assign mem_wmask = mem_w_en ? wmask_q : '0;

  assign ifu_resp_valid = resp && (gnt_q == GNT_IFU);
  assign lsu_resp_valid = resp && (gnt_q == GNT_LSU);
  assign ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
  assign lsu_rdata      = lsu_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: grant table, directed corner sequences,
// and randomized traffic checked every cycle by a timing-rule reference model.
module tb_ysyx_23060240_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata = 32'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_23060240_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  // Registered-read SRAM; garbage on idle cycles exposes a mistimed capture.
  always @(posedge clk) mem_rdata <= mem_r_en ? rd_val(mem_raddr) : $urandom;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks only "busy", cycles since accept and the latched
  // request; expected outputs follow from the latency rules of the protocol.
  bit          mbusy = 0, mptr = 0, mwho = 0, mwen = 0;
  int          mt = 0;
  logic [31:0] maddr = 0, mwd = 0;
  logic [7:0]  mwm = 0;
  bit          ifu_acc = 0, lsu_acc = 0;
  bit          m_any, m_g, e_r, e_w, rv;

  always @(negedge clk) begin
    ifu_acc = ifu_req_valid && ifu_req_ready;
    lsu_acc = lsu_req_valid && lsu_req_ready;
    if (!rst_n) begin
      mbusy = 0; mptr = 0;
      chk("rst_mem_en", {mem_r_en, mem_w_en, ifu_resp_valid, lsu_resp_valid}, 0);
      chk("rst_rdata", {ifu_rdata, lsu_rdata}, 0);
    end else if (!mbusy) begin
      m_any = ifu_req_valid || lsu_req_valid;
      m_g   = (ifu_req_valid && lsu_req_valid) ? mptr : lsu_req_valid;
      chk("ready", {ifu_req_ready, lsu_req_ready}, {m_any && !m_g, m_any && m_g});
      chk("idle_out", {mem_r_en, mem_w_en, ifu_resp_valid, lsu_resp_valid}, 0);
      if (m_any) begin
        mbusy = 1; mt = 0; mwho = m_g; mwen = m_g && lsu_wen;
        maddr = m_g ? lsu_addr : ifu_addr; mwd = lsu_wdata; mwm = lsu_wmask;
        mptr = !m_g;
      end
    end else begin
      mt++;
      e_r = (mt == 1) && !mwen;
      e_w = (mt == 1) && mwen;
      rv  = mt >= (mwen ? 2 : 3);
      chk("ready_busy", {ifu_req_ready, lsu_req_ready}, 0);
      chk("mem_en", {mem_r_en, mem_w_en}, {e_r, e_w});
      chk("mem_raddr", mem_raddr, e_r ? maddr : 32'h0);
      chk("mem_wreq", {mem_waddr, mem_wdata}, e_w ? {maddr, mwd} : 64'h0);
      chk("mem_wmask", mem_wmask, e_w ? mwm : 8'h0);
      chk("resp_valid", {ifu_resp_valid, lsu_resp_valid}, {rv && !mwho, rv && mwho});
      chk("ifu_rdata", ifu_rdata, (rv && !mwho) ? rd_val(maddr) : 32'h0);
      chk("lsu_rdata", lsu_rdata, (rv && mwho && !mwen) ? rd_val(maddr) : 32'h0);
      if (rv && (mwho ? lsu_resp_ready : ifu_resp_ready)) mbusy = 0;
    end
  end

  // One directed transaction with resp_ready high; reports latency from accept.
  task automatic txn(input bit is_lsu, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] m, output int lat, output int nr, output int nw,
                     output logic [31:0] rd, output logic [31:0] wa, output logic [31:0] wd,
                     output logic [7:0] wm);
    int acc_c;
    acc_c = -1; lat = -1; nr = 0; nw = 0; rd = 0; wa = 0; wd = 0; wm = 0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    if (is_lsu) begin
      lsu_req_valid = 1; lsu_wen = wr; lsu_addr = a; lsu_wdata = d; lsu_wmask = m;
    end else begin
      ifu_req_valid = 1; ifu_addr = a;
    end
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_r_en) nr++;
      if (mem_w_en) begin nw++; wa = mem_waddr; wd = mem_wdata; wm = mem_wmask; end
      if (acc_c >= 0 && (is_lsu ? lsu_resp_valid : ifu_resp_valid)) begin
        lat = c - acc_c;
        rd  = is_lsu ? lsu_rdata : ifu_rdata;
      end
      if (acc_c < 0 && (is_lsu ? lsu_req_ready : ifu_req_ready)) acc_c = c;
      @(posedge clk); #1;
      if (acc_c >= 0) begin ifu_req_valid = 0; lsu_req_valid = 0; end
    end
  endtask

  typedef struct {
    bit iv;
    bit lv;
    bit e_ir;
    bit e_lr;
  } vec_t;

  vec_t        vt[4];
  int          lat, nr, nw, cnt;
  logic [31:0] rd, wa, wd, rd0;
  logic [7:0]  wm;
  bit          seen;
  int          gq[$];

  initial begin
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
    lsu_resp_ready = 0;
    vt[0] = '{0, 0, 0, 0};
    vt[1] = '{1, 0, 1, 0};
    vt[2] = '{0, 1, 0, 1};
    vt[3] = '{1, 1, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {ifu_req_ready, lsu_req_ready}, 0);
    chk("reset_mem", {mem_raddr, mem_waddr}, 0);
    chk("reset_wdata", {mem_wdata, 24'h0, mem_wmask}, 0);
    #2 rst_n = 1;

    // Combinational grant in IDLE with the pointer at its reset value.
    foreach (vt[i]) begin
      @(negedge clk); #1;
      ifu_req_valid = vt[i].iv; lsu_req_valid = vt[i].lv;
      ifu_addr = 32'h100; lsu_addr = 32'h200; lsu_wen = 0;
      #1;
      chk($sformatf("grant_tbl%0d", i), {ifu_req_ready, lsu_req_ready}, {vt[i].e_ir, vt[i].e_lr});
      ifu_req_valid = 0; lsu_req_valid = 0;
    end

    @(posedge clk); #1;
    txn(0, 0, 32'h8000_0000, 0, 0, lat, nr, nw, rd, wa, wd, wm);
    chk("ifu_read_lat", lat, 3);
    chk("ifu_read_ren", {nr, nw}, {32'd1, 32'd0});
    chk("ifu_read_data", rd, 32'hDEAD_BEEF);

    txn(1, 1, 32'h8000_0010, 32'h1234_5678, 8'h0F, lat, nr, nw, rd, wa, wd, wm);
    chk("lsu_wr_lat", lat, 2);
    chk("lsu_wr_wen", {nr, nw}, {32'd0, 32'd1});
    chk("lsu_wr_req", {wa, wd}, {32'h8000_0010, 32'h1234_5678});
    chk("lsu_wr_mask", wm, 8'h0F);
    chk("lsu_wr_rdata", rd, 0);

    txn(1, 1, 32'h8000_0020, 32'hCAFE_F00D, 8'h00, lat, nr, nw, rd, wa, wd, wm);
    chk("mask0_wen", nw, 1);
    chk("mask0_mask", wm, 8'h00);

    txn(1, 0, 32'h8000_0044, 0, 0, lat, nr, nw, rd, wa, wd, wm);
    chk("lsu_rd_lat", lat, 3);
    chk("lsu_rd_data", rd, rd_val(32'h8000_0044));

    // Both valid from reset: strict alternation starting with IFU.
    rst_n = 0;
    @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    ifu_req_valid = 1; ifu_addr = 32'h8000_1000;
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_2000; lsu_wdata = 32'hA5A5_0001; lsu_wmask = 8'hFF;
    for (int c = 0; c < 60 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (ifu_req_ready) gq.push_back(0);
      if (lsu_req_ready) gq.push_back(1);
    end
    @(posedge clk); #1;
    ifu_req_valid = 0; lsu_req_valid = 0;
    chk("rr_count", gq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), (i < gq.size()) ? gq[i] : -1, i % 2);
    repeat (8) @(posedge clk);
    #1;

    // Response back-pressure: everything frozen while lsu_resp_ready is low.
    lsu_resp_ready = 0; ifu_resp_ready = 1;
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0100;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = lsu_req_ready; end
    @(posedge clk); #1;
    lsu_req_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0300;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = lsu_resp_valid; end
    chk("hold_seen", seen, 1);
    rd0 = lsu_rdata;
    chk("hold_rdata0", rd0, rd_val(32'h8000_0100));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", lsu_resp_valid, 1);
      chk("hold_rdata", lsu_rdata, rd0);
      chk("hold_quiet", {mem_r_en, mem_w_en, ifu_req_ready, lsu_req_ready}, 0);
    end
    @(posedge clk); #1 lsu_resp_ready = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = ifu_req_ready; end
    chk("hold_then_ifu", seen, 1);
    @(posedge clk); #1 ifu_req_valid = 0;
    repeat (6) @(posedge clk);
    #1;

    // Reset while the read waits on SRAM data: transaction is dropped.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = ifu_req_ready; end
    @(posedge clk); #1 ifu_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_wait_ctl", {mem_r_en, mem_w_en, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_wait_data", {ifu_rdata, mem_raddr}, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      cnt += int'(ifu_resp_valid) + int'(lsu_resp_valid) + int'(mem_r_en) + int'(mem_w_en);
    end
    chk("rst_no_resp", cnt, 0);
    @(posedge clk); #1;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0400;
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0500; lsu_wdata = 32'h0BAD_F00D; lsu_wmask = 8'h3C;
    @(negedge clk);
    chk("rst_ifu_prio", {ifu_req_ready, lsu_req_ready}, 2'b10);

    // Random traffic; requesters hold their payload until accepted.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (!ifu_req_valid || ifu_acc) begin
        ifu_req_valid = ($urandom_range(0, 2) != 0);
        ifu_addr = $urandom;
      end
      if (!lsu_req_valid || lsu_acc) begin
        lsu_req_valid = ($urandom_range(0, 2) != 0);
        lsu_wen = $urandom_range(0, 1) != 0;
        lsu_addr = $urandom;
        lsu_wdata = $urandom;
        lsu_wmask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      ifu_resp_ready = ($urandom_range(0, 3) != 0);
      lsu_resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    if (ifu_acc) ifu_req_valid = 0;
    if (lsu_acc) lsu_req_valid = 0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (ifu_acc) ifu_req_valid = 0;
      if (lsu_acc) lsu_req_valid = 0;
    end
    @(negedge clk);
    chk("drain_idle", {ifu_resp_valid, lsu_resp_valid, mem_r_en, mem_w_en}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
